// File: rtl/seg7_pkg.sv
// Shared segment encodings and state type for the 7-segment display path.
// Bus order: bit7=a .. bit1=g, bit0=dp.
package seg7_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] SEG_0   = 8'hFC;
  localparam logic [7:0] SEG_1   = 8'h60;
  localparam logic [7:0] SEG_2   = 8'hDA;
  localparam logic [7:0] SEG_3   = 8'hF2;
  localparam logic [7:0] SEG_4   = 8'h66;
  localparam logic [7:0] SEG_5   = 8'hB6;
  localparam logic [7:0] SEG_6   = 8'hBE;
  localparam logic [7:0] SEG_7   = 8'hE0;
  localparam logic [7:0] SEG_8   = 8'hFE;
  localparam logic [7:0] SEG_9   = 8'hE6;
  localparam logic [7:0] SEG_ERR = 8'h00;

  typedef enum logic {
    SYNC   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern to BCD decoder.
// Any pattern with dp set, or not in the table, is reported illegal.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [7:0] seg_i,
  output logic [3:0] digit_o,
  output logic       legal_o
);

  always_comb begin
    digit_o = 4'd0;
    legal_o = 1'b1;
    case (seg_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: legal_o = 1'b0;
    endcase
    if (seg_i[SEG_DP]) legal_o = 1'b0;
  end

endmodule

// File: rtl/seg7_monitor.sv
// Receive-side monitor: debounces the segment bus, decodes it and checks
// that accepted digits follow the 0..9 wrap-around count.
module seg7_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       seg_in,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             new_digit,
  output logic             illegal,
  output logic             seq_err,
  output logic [CNT_W-1:0] err_count,
  output logic             locked
);

  localparam logic [3:0] STAB = 4'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [7:0]       seg_q;
  logic [3:0]       cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             same;
  state_e           state_q, state_d;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             new_q, new_d;
  logic             ill_q, ill_d;
  logic             seq_q, seq_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             err_inc;
  logic [3:0]       dec_digit;
  logic             dec_legal;
  logic [3:0]       nxt_digit;

  seg7_decode u_dec (
    .seg_i   (seg_q),
    .digit_o (dec_digit),
    .legal_o (dec_legal)
  );

  // acceptance fires only on the edge where the run first reaches STAB
  always_comb begin
    same  = (seg_in == seg_q);
    cnt_d = 4'd1;
    if (same) cnt_d = (cnt_q == STAB) ? cnt_q : cnt_q + 4'd1;
    acc_d = (cnt_d == STAB) && (!same || cnt_q != STAB);
  end

  assign nxt_digit = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    valid_d = valid_q;
    new_d   = 1'b0;
    ill_d   = 1'b0;
    seq_d   = 1'b0;
    err_inc = 1'b0;
    if (acc_q) begin
      if (!dec_legal) begin
        ill_d   = 1'b1;
        err_inc = 1'b1;
        valid_d = 1'b0;
        state_d = SYNC;
      end else if (state_q == SYNC) begin
        digit_d = dec_digit;
        valid_d = 1'b1;
        new_d   = 1'b1;
        state_d = LOCKED;
      end else if (dec_digit == nxt_digit) begin
        digit_d = dec_digit;
        new_d   = 1'b1;
      end else if (dec_digit != digit_q) begin
        seq_d   = 1'b1;
        err_inc = 1'b1;
        digit_d = dec_digit;
        new_d   = 1'b1;
      end
    end
    err_d = err_q;
    if (err_inc && err_q != '1) err_d = err_q + ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q   <= SEG_ERR;
      cnt_q   <= 4'd0;
      acc_q   <= 1'b0;
      state_q <= SYNC;
      digit_q <= 4'd0;
      valid_q <= 1'b0;
      new_q   <= 1'b0;
      ill_q   <= 1'b0;
      seq_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      seg_q   <= seg_in;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      state_q <= state_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      new_q   <= new_d;
      ill_q   <= ill_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign new_digit   = new_q;
  assign illegal     = ill_q;
  assign seq_err     = seq_q;
  assign err_count   = err_q;
  assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_seg7_monitor.sv
// Directed bench for seg7_monitor: debounce latency, count sequence,
// glitch rejection, sequence/illegal errors, saturation and async reset.
module tb_seg7_monitor;

  logic       clk;
  logic       rst;
  logic [7:0] seg_in;

  logic [3:0] digit, digit2;
  logic       valid, valid2;
  logic       nd, nd2;
  logic       ill, ill2;
  logic       sq, sq2;
  logic [7:0] errc;
  logic [1:0] errc2;
  logic       lk, lk2;

  int n_cmp = 0;
  int n_bad = 0;
  int nd_cnt = 0;
  int ill_cnt = 0;
  int sq_cnt = 0;
  int b_nd, b_ill, b_sq;

  seg7_monitor #(.STABLE_CYCLES(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in),
    .digit(digit), .digit_valid(valid), .new_digit(nd),
    .illegal(ill), .seq_err(sq), .err_count(errc), .locked(lk)
  );

  seg7_monitor #(.STABLE_CYCLES(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .seg_in(seg_in),
    .digit(digit2), .digit_valid(valid2), .new_digit(nd2),
    .illegal(ill2), .seq_err(sq2), .err_count(errc2), .locked(lk2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (nd)  nd_cnt  <= nd_cnt + 1;
      if (ill) ill_cnt <= ill_cnt + 1;
      if (sq)  sq_cnt  <= sq_cnt + 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] v, input int n);
    seg_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    b_nd  = nd_cnt;
    b_ill = ill_cnt;
    b_sq  = sq_cnt;
  endtask

  logic [7:0] cnt_seq [11];
  logic [7:0] bad_seq [5];

  initial begin
    cnt_seq = '{8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE,
                8'hE0, 8'hFE, 8'hE6, 8'hFC, 8'h60};
    bad_seq = '{8'h00, 8'hFD, 8'h01, 8'h02, 8'h03};
    rst = 1'b0;
    seg_in = 8'hFC;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_digit", digit, 0);
    chk("rst_valid", valid, 0);
    chk("rst_locked", lk, 0);
    chk("rst_err", errc, 0);
    chk("rst_nd", nd, 0);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("lat_nd_e2", nd, 0);
    @(posedge clk);
    #1;
    chk("lat_nd_e3", nd, 1);
    chk("lat_digit", digit, 0);
    chk("lat_valid", valid, 1);
    chk("lat_locked", lk, 1);
    chk("lat_err", errc, 0);
    @(posedge clk);
    #1;
    chk("lat_nd_once", nd, 0);

    for (int i = 0; i < 11; i++) drive(cnt_seq[i], 4);
    chk("seq_nd_total", nd_cnt, 12);
    chk("seq_no_seqerr", sq_cnt, 0);
    chk("seq_err", errc, 0);
    chk("seq_digit", digit, 1);

    drive(8'hDA, 4);
    drive(8'hF2, 4);
    mark();
    drive(8'hF2, 2);
    drive(8'h66, 1);
    drive(8'hF2, 4);
    chk("glitch_nd", nd_cnt - b_nd, 0);
    chk("glitch_sq", sq_cnt - b_sq, 0);
    chk("glitch_ill", ill_cnt - b_ill, 0);
    chk("glitch_digit", digit, 3);

    drive(8'h66, 4);
    chk("d4_digit", digit, 4);
    mark();
    drive(8'hBE, 4);
    chk("skip_sq", sq_cnt - b_sq, 1);
    chk("skip_nd", nd_cnt - b_nd, 1);
    chk("skip_err", errc, 1);
    chk("skip_digit", digit, 6);
    chk("skip_locked", lk, 1);
    mark();
    drive(8'hE0, 4);
    chk("d7_nd", nd_cnt - b_nd, 1);
    chk("d7_sq", sq_cnt - b_sq, 0);
    chk("d7_digit", digit, 7);
    chk("d7_err", errc, 1);

    mark();
    drive(8'h00, 4);
    drive(8'hFD, 4);
    chk("ill_pulses", ill_cnt - b_ill, 2);
    chk("ill_err", errc, 3);
    chk("ill_valid", valid, 0);
    chk("ill_locked", lk, 0);
    chk("ill_digit_held", digit, 7);
    mark();
    drive(8'h60, 4);
    chk("relock_digit", digit, 1);
    chk("relock_locked", lk, 1);
    chk("relock_valid", valid, 1);
    chk("relock_sq", sq_cnt - b_sq, 0);
    chk("relock_err", errc, 3);
    chk("w2_err_pre", errc2, 3);

    mark();
    for (int i = 0; i < 5; i++) drive(bad_seq[i], 4);
    chk("sat_pulses", ill_cnt - b_ill, 5);
    chk("sat_err8", errc, 8);
    chk("sat_err2", errc2, 3);
    chk("sat_ill2_pulse", ill2, 0);

    drive(8'h60, 4);
    drive(8'hDA, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_digit", digit, 0);
    chk("arst_valid", valid, 0);
    chk("arst_locked", lk, 0);
    chk("arst_err", errc, 0);
    chk("arst_err2", errc2, 0);
    chk("arst_nd", nd, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("arst_hold_nd", nd_cnt - b_nd, 1);
    chk("arst_hold_locked", lk, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg7_monitor.md
Name: seg7_monitor

Overview:
- Receive-side counterpart of the team's 7-segment counter driver.
- Samples an 8-bit segment bus, waits until the pattern has been stable for a set number of cycles, then decodes it back to a BCD digit.
- Checks that successive digits follow the 0..9 wrap-around count.
- Sits on the verification/self-check side of the display path; reports illegal patterns and sequence breaks with a saturating error counter.

Parameters:
- STABLE_CYCLES, 2, consecutive identical registered samples required before a pattern is accepted (legal range 1..15).
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- seg_in  input  8  segment bus: bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
- digit  output  4  last accepted digit, 0..9.
- digit_valid  output  1  high while digit holds a legal accepted value.
- new_digit  output  1  one-cycle pulse when digit is updated.
- illegal  output  1  one-cycle pulse when an accepted pattern is not a legal digit.
- seq_err  output  1  one-cycle pulse when a legal digit is not previous+1 mod 10.
- err_count  output  CNT_W  count of illegal plus seq_err events, saturating at all-ones.
- locked  output  1  high in the LOCKED state.

Behaviour:
- Reset (rst=0, async) values:
  - digit=0, digit_valid=0, new_digit=0, illegal=0, seq_err=0, err_count=0, locked=0.
  - Internal: sample register=8'h00, stability counter=0, state=SYNC.
  - Reset mid-operation discards any partially stabilised pattern.
- Input stage:
  - seg_in is registered every clk into seg_q.
  - Stability counter: if seg_q equals the previous seg_q, increment, saturating at STABLE_CYCLES; otherwise reload 1.
- Acceptance:
  - Fires exactly once per stable run, in the cycle the counter first reaches STABLE_CYCLES.
  - A run that stays stable longer never re-fires.
  - All outputs are registered. A new value presented on seg_in and then held produces its pulse STABLE_CYCLES+1 rising edges after it first appears.
- Legal patterns (dp must be 0):
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=E6.
  - Every other value is illegal, including 8'h00 (the driver's error output) and any value with dp=1.
- States: SYNC (no trusted reference digit) and LOCKED.
- On acceptance, illegal pattern, in either state:
  - illegal pulse, err_count+1, digit_valid=0, digit held, go to SYNC.
- On acceptance, legal digit d in SYNC:
  - digit=d, digit_valid=1, new_digit pulse, go to LOCKED.
  - No error, whatever d is.
- On acceptance, legal digit d in LOCKED:
  - d==(digit+1) mod 10 (9 to 0 wrap included): digit=d, new_digit pulse.
  - d==digit: no pulse, no error (a re-stabilised glitch).
  - Any other d: seq_err pulse, err_count+1, digit=d, new_digit pulse, stay LOCKED (resynchronise).
- Only one acceptance can occur per cycle, so illegal and seq_err are mutually exclusive.
- err_count holds at 2^CNT_W-1; events are still pulsed after saturation.

Decomposition:
- Package seg7_pkg:
  - Constants SEG_0..SEG_9 and SEG_ERR (8'h00).
  - Segment bit-index constants.
  - State encoding (SYNC, LOCKED).
- Sub-module seg7_decode: purely combinational; seg[7:0] in, digit[3:0] and legal out. It shares the constants with the driver so the two cannot drift.
- seg7_monitor instantiates seg7_decode on seg_q.

Test Plan:
- Reset released, seg_in held at FC -> new_digit pulse on edge 3 after release (STABLE_CYCLES=2); digit=0, digit_valid=1, locked=1, err_count=0.
- Drive the sequence 0..9,0,1, each value held 4 cycles -> 12 new_digit pulses in total (including the initial 0), 9 to 0 wrap accepted, seq_err never pulses, err_count=0.
- While LOCKED at 3, drive F2 (3) then 66 for 1 cycle then back to F2 -> single-cycle 66 never accepted; return to 3 causes no pulse and no error.
- While LOCKED at 4, drive BE (6) -> seq_err pulse, err_count=1, digit=6; then E0 (7) -> clean new_digit, no error.
- Drive 8'h00, then 8'hFD (dp set) -> two illegal pulses, err_count+2, digit_valid=0, locked=0; then 60 -> digit=1, relocks with no seq_err.
- With CNT_W=2, inject 5 illegal patterns -> err_count saturates at 3. Assert rst=0 mid-stabilisation -> all outputs clear immediately, asynchronously.
